// File: rtl/expr_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// expr_sweep_ctrl
//   Sequencer for exhaustive expression checks. Sweeps every stimulus vector
//   0 .. 2**A_WIDTH-1 onto dut_a, then compares the DUT response against the
//   golden response LAT cycles later under a care mask. It counts mismatching
//   vectors (saturating) and remembers the first failing vector.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a sweep (only honoured in IDLE)
//   abort       stop the sweep and discard in-flight vectors
//   dut_a       stimulus to the DUT and the golden model
//   dut_y       DUT response
//   ref_y       golden response
//   ref_mask    1 = bit compared, 0 = don't-care; sampled with ref_y
//   busy        high while running or draining
//   done        one-cycle pulse when a sweep completes or aborts
//   pass        valid after done: no mismatches and not aborted
//   err_cnt     number of mismatching vectors, saturating
//   first_fail  stimulus of the first mismatch, 0 if none
//   fail_seen   at least one mismatch in this sweep
// ---------------------------------------------------------------------------
module expr_sweep_ctrl #(
    parameter int A_WIDTH = 3,
    parameter int Y_WIDTH = 8,
    parameter int LAT     = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [A_WIDTH-1:0] dut_a,
    input  logic [Y_WIDTH-1:0] dut_y,
    input  logic [Y_WIDTH-1:0] ref_y,
    input  logic [Y_WIDTH-1:0] ref_mask,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [A_WIDTH-1:0] first_fail,
    output logic               fail_seen
);

    localparam logic [A_WIDTH-1:0] A_MAX   = {A_WIDTH{1'b1}};
    localparam logic [A_WIDTH-1:0] A_ONE   = A_WIDTH'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [A_WIDTH-1:0]   dut_a_r, dut_a_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 pass_r, pass_s;
    logic [CNT_W-1:0]     err_cnt_r, err_cnt_s;
    logic [A_WIDTH-1:0]   first_fail_r, first_fail_s;
    logic                 fail_seen_r, fail_seen_s;

    logic                 issue_valid_s;
    logic                 abort_hit_s;
    logic                 cmp_valid_s;
    logic [A_WIDTH-1:0]   cmp_vec_s;
    logic                 mismatch_s;

    // A vector counts as issued in every RUN cycle; abort only matters while busy.
    assign issue_valid_s = (state_r == S_RUN);
    assign abort_hit_s   = abort && (state_r != S_IDLE);
    assign mismatch_s    = |((dut_y ^ ref_y) & ref_mask);

    generate
        if (LAT == 0) begin : g_comb
            // Combinational DUT: compare in the issue cycle.
            assign cmp_valid_s = issue_valid_s;
            assign cmp_vec_s   = dut_a_r;
        end else begin : g_pipe
            logic [LAT-1:0]     vld_r;
            logic [A_WIDTH-1:0] vec_r [0:LAT-1];

            // Valid-bit shift line; reset and abort drop every in-flight vector.
            always_ff @(posedge clk) begin
                if (rst || abort_hit_s) begin
                    vld_r <= '0;
                end else begin
                    vld_r[0] <= issue_valid_s;
                    for (int i = 1; i < LAT; i++) begin
                        vld_r[i] <= vld_r[i-1];
                    end
                end
            end

            // Vector shift line travelling alongside the valid bits.
            always_ff @(posedge clk) begin
                vec_r[0] <= dut_a_r;
                for (int i = 1; i < LAT; i++) begin
                    vec_r[i] <= vec_r[i-1];
                end
            end

            assign cmp_valid_s = vld_r[LAT-1];
            assign cmp_vec_s   = vec_r[LAT-1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_s      = state_r;
        dut_a_s      = dut_a_r;
        done_s       = 1'b0;
        pass_s       = pass_r;
        err_cnt_s    = err_cnt_r;
        first_fail_s = first_fail_r;
        fail_seen_s  = fail_seen_r;

        // Result bookkeeping for the vector reaching the compare point;
        // skipped when abort discards the in-flight work.
        if ((state_r != S_IDLE) && !abort && cmp_valid_s && mismatch_s) begin
            if (err_cnt_r != CNT_MAX) begin
                err_cnt_s = err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_s = err_cnt_r;
            end
            if (!fail_seen_r) begin
                first_fail_s = cmp_vec_s;
                fail_seen_s  = 1'b1;
            end else begin
                first_fail_s = first_fail_r;
            end
        end else begin
            err_cnt_s = err_cnt_r;
        end

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s      = S_RUN;
                    dut_a_s      = '0;
                    pass_s       = 1'b0;
                    err_cnt_s    = '0;
                    first_fail_s = '0;
                    fail_seen_s  = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                    pass_s  = 1'b0;
                end else if (dut_a_r == A_MAX) begin
                    // Last vector issued: hold dut_a while the pipe drains.
                    if (LAT == 0) begin
                        state_s = S_IDLE;
                        done_s  = 1'b1;
                        pass_s  = (err_cnt_s == '0);
                    end else begin
                        state_s = S_DRAIN;
                    end
                end else begin
                    dut_a_s = dut_a_r + A_ONE;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                    pass_s  = 1'b0;
                end else if (cmp_valid_s && (cmp_vec_s == A_MAX)) begin
                    // Final vector compared this cycle: the pipe is now empty.
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                    pass_s  = (err_cnt_s == '0);
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // Output and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_cnt_r    <= '0;
            first_fail_r <= '0;
            fail_seen_r  <= 1'b0;
        end else begin
            dut_a_r      <= dut_a_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            err_cnt_r    <= err_cnt_s;
            first_fail_r <= first_fail_s;
            fail_seen_r  <= fail_seen_s;
        end
    end

    assign dut_a      = dut_a_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_cnt    = err_cnt_r;
    assign first_fail = first_fail_r;
    assign fail_seen  = fail_seen_r;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expr_sweep_ctrl
//   Two controllers share clock, reset, start and abort: one with the default
//   configuration (A_WIDTH=3, LAT=2, CNT_W=8) and one with LAT=0, CNT_W=2 to
//   exercise the combinational-DUT path and counter saturation. The bench plays
//   the expression-under-test: per-vector tables give dut_y, ref_y, ref_mask,
//   presented LAT cycles after the vector appears on dut_a. Expected results
//   come from a direct count over the tables.
// ---------------------------------------------------------------------------
module tb_expr_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;

    logic [2:0] a_m, ff_m;
    logic [7:0] y_m, r_m, k_m, cnt_m;
    logic       busy_m, done_m, pass_m, fs_m;

    logic [2:0] a_s, ff_s;
    logic [7:0] y_s, r_s, k_s;
    logic [1:0] cnt_s;
    logic       busy_s, done_s, pass_s, fs_s;

    logic [7:0] tdut [0:7];
    logic [7:0] tref [0:7];
    logic [7:0] tmask [0:7];

    logic [2:0] h0 = 3'd0, h1 = 3'd0, h2 = 3'd0;

    int n_vec = 0;
    int n_bad = 0;

    expr_sweep_ctrl #(.A_WIDTH(3), .Y_WIDTH(8), .LAT(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(a_m), .dut_y(y_m), .ref_y(r_m), .ref_mask(k_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(cnt_m),
        .first_fail(ff_m), .fail_seen(fs_m)
    );

    expr_sweep_ctrl #(.A_WIDTH(3), .Y_WIDTH(8), .LAT(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(a_s), .dut_y(y_s), .ref_y(r_s), .ref_mask(k_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(cnt_s),
        .first_fail(ff_s), .fail_seen(fs_s)
    );

    // Expression-under-test stand-in: responses for the vector issued LAT cycles ago.
    always @(negedge clk) begin
        h2 = h1;
        h1 = h0;
        h0 = a_m;
        y_m = tdut[h2];
        r_m = tref[h2];
        k_m = tmask[h2];
        y_s = tdut[a_s];
        r_s = tref[a_s];
        k_s = tmask[a_s];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 clean, 1 vectors 5/6 differ, 2 diffs only in masked-off bits, 3 all fail, 4 random
    task automatic set_tables(input int mode);
        for (int v = 0; v < 8; v++) begin
            tref[v] = 8'($urandom);
            case (mode)
                0: begin tmask[v] = 8'($urandom); tdut[v] = tref[v]; end
                1: begin tmask[v] = 8'hFF; tdut[v] = (v == 5 || v == 6) ? (tref[v] ^ 8'h10) : tref[v]; end
                2: begin tmask[v] = 8'($urandom) & 8'hF7; tdut[v] = tref[v] ^ ~tmask[v]; end
                3: begin tmask[v] = 8'hFF; tdut[v] = ~tref[v]; end
                default: begin
                    tmask[v] = 8'($urandom);
                    tdut[v]  = ($urandom_range(0, 2) == 0) ? (tref[v] ^ 8'($urandom)) : tref[v];
                end
            endcase
        end
    endtask

    task automatic model(output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int v = 0; v < 8; v++) begin
            if (|((tdut[v] ^ tref[v]) & tmask[v])) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
    endtask

    task automatic sweep(input bit poke, input bit abort_too);
        int cnt, first, dm, ds, nm, ns;
        model(cnt, first);
        @(negedge clk);
        start = 1'b1;
        abort = abort_too;
        dm = -1; ds = -1; nm = 0; ns = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start = (poke && i == 4);
            abort = 1'b0;
            if (i <= 8) begin
                check_val("dut_a_seq", 32'(a_m), 32'(i - 1));
                check_val("sat_a_seq", 32'(a_s), 32'(i - 1));
            end
            if (i == 1) check_val("busy_run", 32'(busy_m), 32'd1);
            if (done_m) begin nm++; if (dm < 0) dm = i; end
            if (done_s) begin ns++; if (ds < 0) ds = i; end
        end
        check_val("done_latency", 32'(dm), 32'd11);
        check_val("sat_done_latency", 32'(ds), 32'd9);
        check_val("done_pulses", 32'(nm), 32'd1);
        check_val("sat_done_pulses", 32'(ns), 32'd1);
        check_val("err_cnt", 32'(cnt_m), 32'(cnt));
        check_val("sat_err_cnt", 32'(cnt_s), 32'((cnt > 3) ? 3 : cnt));
        check_val("first_fail", 32'(ff_m), 32'(first));
        check_val("sat_first_fail", 32'(ff_s), 32'(first));
        check_val("fail_seen", 32'(fs_m), 32'(cnt != 0));
        check_val("pass", 32'(pass_m), 32'(cnt == 0));
        check_val("sat_pass", 32'(pass_s), 32'(cnt == 0));
        check_val("busy_after", 32'(busy_m), 32'd0);
    endtask

    task automatic abort_run();
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (i == 3);
            if (i == 4) begin
                check_val("abort_done", 32'(done_m), 32'd1);
                check_val("abort_pass", 32'(pass_m), 32'd0);
                check_val("abort_busy", 32'(busy_m), 32'd0);
                check_val("sat_abort_done", 32'(done_s), 32'd1);
                check_val("sat_abort_pass", 32'(pass_s), 32'd0);
            end
            if (i == 5) check_val("abort_done_once", 32'(done_m), 32'd0);
        end
    endtask

    task automatic reset_in_drain();
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 9) begin
                check_val("drain_busy", 32'(busy_m), 32'd1);
                rst = 1'b1;
            end
            if (i == 10) begin
                check_val("rst_dut_a", 32'(a_m), 32'd0);
                check_val("rst_busy", 32'(busy_m), 32'd0);
                check_val("rst_done", 32'(done_m), 32'd0);
                check_val("rst_pass", 32'(pass_m), 32'd0);
                check_val("rst_err_cnt", 32'(cnt_m), 32'd0);
                check_val("rst_first_fail", 32'(ff_m), 32'd0);
                check_val("rst_fail_seen", 32'(fs_m), 32'd0);
                check_val("sat_rst_err_cnt", 32'(cnt_s), 32'd0);
                rst = 1'b0;
            end
            if (i > 10) check_val("no_done_after_rst", 32'(done_m), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_tables(0);
        repeat (3) @(negedge clk);
        check_val("reset_dut_a", 32'(a_m), 32'd0);
        check_val("reset_busy", 32'(busy_m), 32'd0);
        check_val("reset_done", 32'(done_m), 32'd0);
        check_val("reset_pass", 32'(pass_m), 32'd0);
        check_val("reset_err_cnt", 32'(cnt_m), 32'd0);
        check_val("reset_first_fail", 32'(ff_m), 32'd0);
        check_val("reset_fail_seen", 32'(fs_m), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_tables(0); sweep(1'b0, 1'b0);   // clean sweep
        set_tables(1); sweep(1'b0, 1'b0);   // vectors 5 and 6 fail
        set_tables(2); sweep(1'b1, 1'b0);   // masked-only diffs, start while busy
        set_tables(3); sweep(1'b0, 1'b1);   // all fail, abort with start in IDLE
        set_tables(0); abort_run();
        set_tables(0); sweep(1'b0, 1'b0);   // clean re-run after abort
        set_tables(1); reset_in_drain();
        set_tables(1); sweep(1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            set_tables($urandom_range(0, 4));
            sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
